fact_accel: RTL
===============

// Module: fact_accel
// PURPOSE
//  Memory-mapped iterative factorial accelerator on the MIPS32 system data bus, downstream of the MEM stage address decoder.
//  Software writes n, pulses GO, polls STATUS, then reads RESULT. This offloads the factorial loop from the core.
//  One multiply per cycle. Overflow detection rejects n > MAX_N.
// PARAMETERS
//  WIDTH   32  data/result width
//  N_W      4  width of the n operand register
//  MAX_N   12  largest n whose factorial fits in WIDTH bits; larger n -> error
// PORTS
//  clk    in   1      system clock, all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  we     in   1      bus write enable, qualified by decoder select
//  addr   in   2      word address (byte addr[3:2]): 0=N 1=GO 2=STATUS 3=RESULT
//  wd     in   WIDTH  write data
//  rd     out  WIDTH  read data, combinational from addr
//  irq    out  1      only when FACT_IRQ_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; n_reg=0, acc=0, cnt=0, result=0, done=0, err=0, irq=0; rd reflects the cleared registers.
//  - Register map, reads:
//      0 -> {0, n_reg}
//      1 -> {0, busy}
//      2 -> {30'b0, err, done}
//      3 -> result
//  - Write N (addr 0): n_reg <= wd[N_W-1:0], only in IDLE or DONE; ignored while busy.
//  - Write GO (addr 1, wd[0]=1): accepted in IDLE or DONE.
//      Same edge: done<=0, err<=0, state<=LOAD.
//      Ignored while busy (LOAD/MULT). wd[0]=0 has no effect. Writes to addr 2 and 3 are ignored.
//  - FSM states: IDLE, LOAD, MULT, DONE. busy = (state==LOAD || state==MULT).
//      LOAD: if n_reg>MAX_N -> DONE, err<=1, done<=1, result<=0;
//            else acc<=1, cnt<=n_reg, state<=MULT.
//      MULT: if cnt<=1 -> DONE, result<=acc, done<=1;
//            else acc<=acc*cnt (low WIDTH bits), cnt<=cnt-1.
//      DONE: hold result/done/err until next accepted GO or rst.
//  - Latency, counting the GO-write edge as edge 0:
//      done rises at edge max(n,1)+1 for n<=MAX_N;
//      done rises at edge 1 for n>MAX_N.
//  - n=0 and n=1 both yield result=1.
//  - result changes only on entry to DONE; stale result readable while busy.
//  - rst mid-operation aborts to IDLE and clears everything; no partial result is retained.
//  - A bus write on the same edge the FSM enters DONE is evaluated against the pre-edge state, i.e. busy, so it is ignored.
// CONFIGURATION
//  FACT_IRQ_EN defined:
//      irq output port exists.
//      irq<=1 on DONE entry; cleared by an accepted GO or by rst.
//      STATUS bit 2 reads irq.
//  FACT_IRQ_EN undefined:
//      no irq port; STATUS bit 2 reads 0; behaviour otherwise identical.
// TESTING
//  1. Assert rst for 1 cycle -> rd=0 at every addr; state IDLE; irq=0 if enabled.
//  2. Write N=5, write GO=1 -> done=0 at edges 1..5; done=1 at edge 6; RESULT=120, STATUS=0x1.
//  3. Sweep n=0..12, polling done each time -> RESULT = 1,1,2,6,...,479001600; err=0 every time.
//  4. n=13, GO -> edge 1 STATUS=0x3, RESULT=0; then n=3, GO -> STATUS=0x1, RESULT=6.
//  5. n=10, GO; at edge 3 write N=2 and GO again -> both ignored; final RESULT=3628800.
//  6. n=12, GO; rst at edge 4 -> IDLE, RESULT=0, done=0; then n=4, GO -> RESULT=24 at edge 5.

Source files
------------

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator (one multiply per cycle).
// Optional completion interrupt enabled by defining FACT_IRQ_EN.
module fact_accel #(
  parameter int WIDTH = 32,
  parameter int N_W   = 4,
  parameter int MAX_N = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wd,
`ifdef FACT_IRQ_EN
  output logic             irq,
`endif
  output logic [WIDTH-1:0] rd
);

  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

  localparam logic [N_W-1:0] MAX_N_C = N_W'(MAX_N);
  localparam logic [N_W-1:0] ONE_N   = N_W'(1);

  state_t           state, state_nx;
  logic [N_W-1:0]   n_reg, cnt;
  logic [WIDTH-1:0] acc, result;
  logic             done, err, irq_bit;
  logic             busy, ovf, mult_last, enter_done;
  logic             wr_n, go_acc;
  logic             unused_wd;

  assign unused_wd = ^wd[WIDTH-1:N_W];

  // Bus writes are judged against the pre-edge state, so busy masks them.
  assign wr_n   = we && (addr == 2'd0) && !busy;
  assign go_acc = we && (addr == 2'd1) && wd[0] && !busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go_acc) state_nx = LOAD;
      LOAD:    state_nx = ovf ? DONE : MULT;
      MULT:    if (mult_last) state_nx = DONE;
      DONE:    if (go_acc) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == LOAD) || (state == MULT);
    ovf        = n_reg > MAX_N_C;
    mult_last  = cnt <= ONE_N;
    enter_done = ((state == LOAD) && ovf) || ((state == MULT) && mult_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg  <= '0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (wr_n) n_reg <= wd[N_W-1:0];
      if (go_acc) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (state == LOAD) begin
        if (ovf) begin
          err    <= 1'b1;
          done   <= 1'b1;
          result <= '0;
        end else begin
          acc <= WIDTH'(1);
          cnt <= n_reg;
        end
      end
      if (state == MULT) begin
        if (mult_last) begin
          result <= acc;
          done   <= 1'b1;
        end else begin
          acc <= acc * WIDTH'(cnt);
          cnt <= cnt - ONE_N;
        end
      end
    end
  end

`ifdef FACT_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst)             irq_q <= 1'b0;
    else if (enter_done) irq_q <= 1'b1;
    else if (go_acc)     irq_q <= 1'b0;
  end
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd = WIDTH'(n_reg);
      2'd1: rd = WIDTH'(busy);
      2'd2: begin
        rd[0] = done;
        rd[1] = err;
        rd[2] = irq_bit;
      end
      default: rd = result;
    endcase
  end

endmodule
